// File: rtl/lsu_mem_port.sv
// Load/store unit: one byte-addressed access at a time against a word-addressed
// memory, with sub-word read-modify-write stores and sign/zero-extended loads.
module lsu_mem_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  fault_q, fault_d;

  logic [ADDR_WIDTH-1:0] req_idx, idx_q;
  logic                  req_fault;
  logic [4:0]            lane_sh;
  logic [DATA_WIDTH-1:0] rd_sh, lane_mask, merged, load_ext;

  // Request checks and byte-lane extract/merge helpers
  always_comb begin
    req_idx   = req_addr >> 2;
    idx_q     = addr_q >> 2;
    req_fault = (req_size == 2'b11)
             || ((req_size == SZ_HALF) && req_addr[0])
             || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
             || (req_idx >= ADDR_WIDTH'(MEM_SIZE));
    lane_sh   = {addr_q[1:0], 3'b000};
    rd_sh     = mem_read_data >> lane_sh;
    lane_mask = ((size_q == SZ_BYTE) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << lane_sh;
    merged    = (mem_read_data & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? DATA_WIDTH'(rd_sh[7:0])
                                : {{(DATA_WIDTH-8){rd_sh[7]}}, rd_sh[7:0]};
      SZ_HALF: load_ext = uns_q ? DATA_WIDTH'(rd_sh[15:0])
                                : {{(DATA_WIDTH-16){rd_sh[15]}}, rd_sh[15:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_data_d  = wr_data_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          is_store_d = req_is_store;
          size_d     = req_size;
          uns_d      = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          wr_data_d  = req_wdata;
          rdata_d    = '0;
          fault_d    = req_fault;
          if (req_fault)                                state_d = S_RESP;
          else if (req_is_store && req_size == SZ_WORD) state_d = S_WRITE;
          else                                          state_d = S_READ;
        end
      end
      S_READ: begin
        if (is_store_q) begin
          wr_data_d = merged;
          state_d   = S_WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        rdata_d = '0;
        state_d = S_RESP;
      end
      default: begin
        if (resp_ready) begin
          rdata_d = '0;
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_data_q  <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_data_q  <= wr_data_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
    end
  end

  // Port drive decoded from the state register so reset clears it at once
  assign req_ready        = (state_q == S_IDLE) && reset_n;
  assign resp_valid       = (state_q == S_RESP);
  assign resp_rdata       = rdata_q;
  assign resp_fault       = fault_q;
  assign mem_read_enable  = (state_q == S_READ);
  assign mem_read_addr    = mem_read_enable ? idx_q : '0;
  assign mem_write_enable = (state_q == S_WRITE);
  assign mem_write_addr   = mem_write_enable ? idx_q : '0;
  assign mem_write_data   = mem_write_enable ? wr_data_q : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small behavioural word memory.
module tb_lsu_mem_port;

  localparam int unsigned MEM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;

  logic [31:0] mem [0:MEM_SIZE-1];

  int errors = 0;
  int checks = 0;

  logic [31:0] t_rdata, t_ra, t_wa, t_wd;
  logic        t_fault, t_stable;
  int          t_lat, t_nrd, t_nwr;

  lsu_mem_port #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_read_enable(mem_read_enable), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .mem_write_enable(mem_write_enable),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = (mem_read_addr < MEM_SIZE) ? mem[mem_read_addr[9:0]] : 32'h0;

  always @(posedge clk)
    if (mem_write_enable && mem_write_addr < MEM_SIZE)
      mem[mem_write_addr[9:0]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction; response is held back for `hold` cycles before acceptance
  task automatic txn(input logic st, input logic [1:0] sz, input logic un,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold);
    bit got = 0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = un;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    t_lat = 0; t_nrd = 0; t_nwr = 0; t_ra = '0; t_wa = '0; t_wd = '0; t_stable = 1'b1;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (mem_read_enable)  begin t_nrd++; t_ra = mem_read_addr; end
      if (mem_write_enable) begin t_nwr++; t_wa = mem_write_addr; t_wd = mem_write_data; end
      if (resp_valid) begin got = 1; t_lat = c; end
    end
    check("resp_seen", 32'(got), 32'd1);
    t_rdata = resp_rdata;
    t_fault = resp_fault;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== t_rdata || resp_fault !== t_fault || req_ready
          || mem_read_enable || mem_write_enable)
        t_stable = 1'b0;
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  task automatic expect_txn(input string tag, input logic [31:0] rd, input logic flt,
                            input int lat, input int nrd, input int nwr);
    check({tag, "_rdata"}, t_rdata, rd);
    check({tag, "_fault"}, 32'(t_fault), 32'(flt));
    check({tag, "_lat"}, 32'(t_lat), 32'(lat));
    check({tag, "_nrd"}, 32'(t_nrd), 32'(nrd));
    check({tag, "_nwr"}, 32'(t_nwr), 32'(nwr));
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_en", 32'({mem_read_enable, mem_write_enable}), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    reset_n = 1'b1;
    #1 check("post_rst_ready", 32'(req_ready), 32'd1);

    // Word store then word load
    txn(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 0);
    expect_txn("st_w", 32'h0, 1'b0, 2, 0, 1);
    check("st_w_addr", t_wa, 32'd16);
    check("st_w_data", t_wd, 32'hDEADBEEF);
    check("st_w_mem", mem[16], 32'hDEADBEEF);
    txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
    expect_txn("ld_w", 32'hDEADBEEF, 1'b0, 2, 1, 0);
    check("ld_w_addr", t_ra, 32'd16);

    // Byte store (RMW) and byte loads
    txn(1'b1, 2'b00, 1'b0, 32'h41, 32'h123456A5, 0);
    expect_txn("st_b", 32'h0, 1'b0, 3, 1, 1);
    check("st_b_raddr", t_ra, 32'd16);
    check("st_b_waddr", t_wa, 32'd16);
    check("st_b_data", t_wd, 32'hDEADA5EF);
    txn(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 0);
    expect_txn("ld_bs", 32'hFFFFFFA5, 1'b0, 2, 1, 0);
    txn(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 0);
    expect_txn("ld_bu", 32'h000000A5, 1'b0, 2, 1, 0);
    txn(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 0);
    expect_txn("ld_bu0", 32'h000000EF, 1'b0, 2, 1, 0);

    // Half loads
    txn(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 0);
    expect_txn("ld_hs", 32'hFFFFDEAD, 1'b0, 2, 1, 0);
    txn(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 0);
    expect_txn("ld_hu", 32'h0000A5EF, 1'b0, 2, 1, 0);

    // Faults: misaligned, illegal size, out of range
    txn(1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 0);
    expect_txn("f_half", 32'h0, 1'b1, 1, 0, 0);
    txn(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 0);
    expect_txn("f_word", 32'h0, 1'b1, 1, 0, 0);
    txn(1'b1, 2'b11, 1'b0, 32'h40, 32'h55, 0);
    expect_txn("f_size", 32'h0, 1'b1, 1, 0, 0);
    txn(1'b0, 2'b10, 1'b0, 32'(4 * MEM_SIZE), 32'h0, 0);
    expect_txn("f_range", 32'h0, 1'b1, 1, 0, 0);
    check("f_mem_kept", mem[16], 32'hDEADA5EF);

    // Last valid word
    txn(1'b1, 2'b10, 1'b0, 32'(4 * (MEM_SIZE - 1)), 32'h0BADF00D, 0);
    expect_txn("top_st", 32'h0, 1'b0, 2, 0, 1);
    check("top_st_addr", t_wa, 32'(MEM_SIZE - 1));
    txn(1'b0, 2'b01, 1'b0, 32'(4 * (MEM_SIZE - 1) + 2), 32'h0, 0);
    expect_txn("top_ld_hs", 32'h00000BAD, 1'b0, 2, 1, 0);

    // Half store into upper lane
    txn(1'b1, 2'b01, 1'b0, 32'h42, 32'hCAFEBEEF, 0);
    expect_txn("st_h", 32'h0, 1'b0, 3, 1, 1);
    check("st_h_data", t_wd, 32'hBEEFA5EF);

    // Response back-pressure
    txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5);
    expect_txn("bp", 32'hBEEFA5EF, 1'b0, 2, 1, 0);
    check("bp_stable", 32'(t_stable), 32'd1);

    // Reset during the WRITE cycle of a half store
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h00001234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("ar_rd_en", 32'(mem_read_enable), 32'd1);
    @(negedge clk);
    check("ar_wr_en_pre", 32'(mem_write_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check("ar_wr_en", 32'(mem_write_enable), 32'd0);
    check("ar_wr_bus", mem_write_addr | mem_write_data, 32'h0);
    check("ar_outs", 32'({req_ready, resp_valid, resp_fault, mem_read_enable}), 32'd0);
    check("ar_rdata", resp_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("ar_mem_kept", mem[16], 32'hBEEFA5EF);
    reset_n = 1'b1;
    #1 check("ar_ready", 32'(req_ready), 32'd1);
    txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
    expect_txn("ar_ld", 32'hBEEFA5EF, 1'b0, 2, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store access unit sitting between the single-cycle core's execute stage and the word-addressed data memory. It accepts one byte-addressed load or store at a time over a valid/ready handshake and drives the memory's read/write port signals, acting as initiator to the memory's responder. It handles byte, half and word accesses, including read-modify-write for sub-word stores and sign or zero extension on loads. It returns a registered response over a second valid/ready handshake.

## Interface
- DATA_WIDTH, 32: memory word width. Fixed at 32 because the byte-lane logic assumes 4 lanes.
- ADDR_WIDTH, 32: width of the request byte address and of the memory word index.
- MEM_SIZE, 1024: memory depth in words. Used for the range check.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_is_store  in  1  1 selects store, 0 selects load.
- req_size  in  2  00 is byte, 01 is half, 10 is word. 11 is illegal and faults.
- req_unsigned  in  1  loads only: 1 zero-extends, 0 sign-extends.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, taken from the low bits.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data. 0 for stores and for faults.
- resp_fault  out  1  misaligned access, out-of-range access, or illegal size.
- mem_read_enable / mem_read_addr  out  1 / ADDR_WIDTH  memory read port. The address is a word index.
- mem_read_data  in  DATA_WIDTH  combinational read data from the memory.
- mem_write_enable / mem_write_addr / mem_write_data  out  1 / ADDR_WIDTH / DATA_WIDTH  memory write port. The address is a word index.

## Operation
- States: IDLE, READ, WRITE, RESP.
- req_ready is 1 only in IDLE with reset_n high. All mem_* outputs are 0 outside READ and WRITE.
- Accept: req_valid && req_ready at a rising edge. On accept, latch is_store, size, unsigned, addr and wdata.
- Word index = addr >> 2.
- Fault conditions:
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - size 11;
  - word index >= MEM_SIZE.
- Transitions out of IDLE on accept:
  - fault → RESP, with resp_fault = 1 and resp_rdata = 0. No memory enable is asserted.
  - load → READ.
  - word store → WRITE.
  - byte or half store → READ (read-modify-write).
- READ: mem_read_enable = 1 and mem_read_addr = word index.
  - Load: extract, extend and register the result into resp_rdata, then go to RESP.
  - Sub-word store: register the read word as the merge base, then go to WRITE.
- WRITE: mem_write_enable = 1 for exactly one cycle, with mem_write_addr = word index.
  - mem_write_data is either req_wdata (word store) or the merge base with the addressed lane(s) replaced.
  - Next state RESP, with resp_rdata = 0.
- RESP: resp_valid = 1. resp_rdata and resp_fault hold stable until resp_ready. Return to IDLE on the handshake edge.
- Byte lanes are little-endian:
  - byte k occupies bits [8k+7:8k], where k = addr[1:0];
  - a half occupies bits [16h+15:16h], where h = addr[1].
- Extension: sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned is set. Word loads pass through unchanged.
- Only one transaction is in flight. A new request is never accepted in the same cycle as a response handshake.

## Timing
- Reset (reset_n low, asynchronous): state goes to IDLE immediately. req_ready, resp_valid, resp_fault and all mem_* outputs are 0, and resp_rdata is 0.
- After reset_n rises, req_ready = 1.
- Latency, with accept at edge N:
  - fault: resp_valid in cycle N+1.
  - load: READ in N+1, resp_valid in N+2.
  - word store: WRITE in N+1 (memory updated at the end-of-cycle edge), resp_valid in N+2.
  - sub-word store: READ in N+1, WRITE in N+2, resp_valid in N+3.
- The earliest next accept is the cycle after the response handshake. Peak throughput is 1 access per 3 cycles.
- Reset mid-operation: write enable drops combinationally. A store interrupted in READ or WRITE must not modify memory. No response is produced for an aborted transaction.
- Response back-pressure stalls indefinitely without any memory activity.

## Test plan
- Word store of 0xDEADBEEF to 0x40, then word load from 0x40 → mem word 16 = 0xDEADBEEF, resp_rdata = 0xDEADBEEF. resp_valid appears 2 cycles after each accept.
- Byte store of 0xA5 to 0x41 over 0xDEADBEEF → one READ and one WRITE of index 16, data 0xDEADA5EF. Then byte load from 0x41: signed gives 0xFFFFFFA5, unsigned gives 0x000000A5.
- Half load from 0x42 (signed) → 0xFFFFDEAD. Half load from 0x43, word load from 0x42, and size 11 → resp_fault = 1, rdata 0, no mem enable, resp in N+1.
- Word load from byte address 4*MEM_SIZE → fault with no memory access. Index MEM_SIZE-1 → normal access.
- Hold resp_ready low for 5 cycles during a load → resp_valid, resp_rdata and resp_fault stay stable, req_ready = 0, and no mem enables are asserted.
- Assert reset_n low during the WRITE cycle of a half store → mem_write_enable drops immediately, memory is unchanged, and all outputs read 0. After release, req_ready = 1 and a fresh load returns the old data.
